// File: rtl/dist_hazard_pkg.sv
// Shared constants and helpers for the distribution-register hazard unit.
// Holds the default parameter values and a generic packed-vector address slicer.
package dist_hazard_pkg;

    localparam int DEF_NUM_SRC        = 2;
    localparam int DEF_ADDR_W         = 5;
    localparam int DEF_NUM_STAGES     = 2;
    localparam int DEF_MAX_LAT        = 7;
    localparam int DEF_ZERO_HARDWIRED = 0;

    // Widest packed address vector / address the slicer can handle.
    localparam int SLICE_VEC_W  = 512;
    localparam int SLICE_ADDR_W = 16;

    function automatic logic [SLICE_ADDR_W-1:0] addr_at(
        input logic [SLICE_VEC_W-1:0] vec,
        input int unsigned            idx,
        input int unsigned            width
    );
        logic [SLICE_VEC_W-1:0] shifted;
        logic [SLICE_VEC_W-1:0] mask;
        shifted = vec >> (idx * width);
        mask    = ~({SLICE_VEC_W{1'b1}} << width);
        addr_at = SLICE_ADDR_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/dist_fwd_select.sv
// One source operand versus all forwarding stages.
// Produces a one-hot (or zero) select where the youngest matching writer wins.
module dist_fwd_select
    import dist_hazard_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ZERO_HARDWIRED = DEF_ZERO_HARDWIRED
) (
    input  logic [ADDR_W-1:0]            i_src_addr,
    input  logic                         i_src_used,
    input  logic [NUM_STAGES-1:0]        i_stg_wr_en,
    input  logic [NUM_STAGES*ADDR_W-1:0] i_stg_dest_addr,
    output logic [NUM_STAGES-1:0]        o_sel
);

    logic              w_src_ok;
    logic              w_found;
    logic [ADDR_W-1:0] w_dest;

    assign w_src_ok = i_src_used && !((ZERO_HARDWIRED != 0) && (i_src_addr == '0));

    // Scan from youngest (index 0) upward; the first writer that matches claims the operand.
    always_comb begin
        o_sel   = '0;
        w_found = 1'b0;
        w_dest  = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_dest = ADDR_W'(addr_at(SLICE_VEC_W'(i_stg_dest_addr), k, ADDR_W));
            if (!w_found && w_src_ok && i_stg_wr_en[k] && (w_dest == i_src_addr)) begin
                o_sel[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/distribution_hazard_unit.sv
// ID-stage hazard unit for distribution registers: per-source forwarding selects
// plus a latency scoreboard that stalls ID on sources owned by multi-cycle ops.
module distribution_hazard_unit
    import dist_hazard_pkg::*;
#(
    parameter  int NUM_SRC        = DEF_NUM_SRC,
    parameter  int ADDR_W         = DEF_ADDR_W,
    parameter  int NUM_STAGES     = DEF_NUM_STAGES,
    parameter  int MAX_LAT        = DEF_MAX_LAT,
    parameter  int ZERO_HARDWIRED = DEF_ZERO_HARDWIRED,
    localparam int LAT_W          = $clog2(MAX_LAT + 1),
    localparam int NUM_REGS       = 2 ** ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]     id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [NUM_STAGES-1:0]         stg_wr_en,
    input  logic [NUM_STAGES*ADDR_W-1:0]  stg_dest_addr,
    input  logic                          iss_valid,
    input  logic [ADDR_W-1:0]             iss_dest,
    input  logic [LAT_W-1:0]              iss_lat,
    output logic                          iss_ready,
    input  logic                          flush,
    output logic [NUM_SRC*NUM_STAGES-1:0] fwd_sel,
    output logic                          stall,
    output logic [NUM_REGS-1:0]           busy_vec
);

    logic [LAT_W-1:0]  r_cnt [NUM_REGS];
    logic              w_iss_zero;
    logic              w_accept;
    logic              w_stall_any;
    logic [ADDR_W-1:0] w_src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            dist_fwd_select #(
                .NUM_STAGES     (NUM_STAGES),
                .ADDR_W         (ADDR_W),
                .ZERO_HARDWIRED (ZERO_HARDWIRED)
            ) u_sel (
                .i_src_addr      (id_src_addr[gi*ADDR_W +: ADDR_W]),
                .i_src_used      (id_src_used[gi]),
                .i_stg_wr_en     (stg_wr_en),
                .i_stg_dest_addr (stg_dest_addr),
                .o_sel           (fwd_sel[gi*NUM_STAGES +: NUM_STAGES])
            );
        end
    endgenerate

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (r_cnt[r] != '0);
        end
    end

    // Issue handshake: an op transfers on a clock edge where iss_valid && iss_ready;
    // iss_ready depends only on the target entry, never on iss_valid. A zero latency,
    // a hardwired-zero destination or a same-cycle flush drop the op without effect.
    assign iss_ready  = !busy_vec[iss_dest] || (r_cnt[iss_dest] == LAT_W'(1));
    assign w_iss_zero = (ZERO_HARDWIRED != 0) && (iss_dest == '0);
    assign w_accept   = iss_valid && iss_ready && (iss_lat != '0) && !flush && !w_iss_zero;

    // Reload wins over decrement so a WAW issue on the final cycle leaves no gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (flush) begin
                    r_cnt[r] <= '0;
                end else if (w_accept && (iss_dest == ADDR_W'(r))) begin
                    r_cnt[r] <= iss_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_stall_any = 1'b0;
        w_src       = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = ADDR_W'(addr_at(SLICE_VEC_W'(id_src_addr), i, ADDR_W));
            if (id_src_used[i] && busy_vec[w_src] &&
                !((ZERO_HARDWIRED != 0) && (w_src == '0))) begin
                w_stall_any = 1'b1;
            end
        end
    end

    assign stall = id_valid && w_stall_any;

endmodule

// File: tb/tb_distribution_hazard_unit.sv
// Self-checking bench for distribution_hazard_unit: forwarding table, random
// forwarding against a reference model, and scoreboard timing sequences.
module tb_distribution_hazard_unit;

  localparam int NUM_SRC    = 2;
  localparam int ADDR_W     = 5;
  localparam int NUM_STAGES = 2;
  localparam int MAX_LAT    = 7;
  localparam int LAT_W      = 3;
  localparam int NUM_REGS   = 32;
  localparam int OUT_W      = NUM_SRC * NUM_STAGES + 2;

  logic                 clk;
  logic                 rst;
  logic                 id_valid;
  logic [9:0]           id_src_addr;
  logic [1:0]           id_src_used;
  logic [1:0]           stg_wr_en;
  logic [9:0]           stg_dest_addr;
  logic                 iss_valid;
  logic [ADDR_W-1:0]    iss_dest;
  logic [LAT_W-1:0]     iss_lat;
  logic                 flush;
  logic                 iss_ready,   iss_ready_z;
  logic [3:0]           fwd_sel,     fwd_sel_z;
  logic                 stall,       stall_z;
  logic [NUM_REGS-1:0]  busy_vec,    busy_vec_z;

  int n_vec  = 0;
  int n_fail = 0;
  logic [OUT_W-1:0] exp_q[$];
  string            name_q[$];

  typedef struct {
    string      name;
    logic [9:0] src;
    logic [1:0] used;
    logic [1:0] wr;
    logic [9:0] dest;
    logic [3:0] exp_fwd;
    logic [3:0] exp_fwd_z;
  } vec_t;
  vec_t tbl[$];

  distribution_hazard_unit #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .NUM_STAGES(NUM_STAGES),
    .MAX_LAT(MAX_LAT), .ZERO_HARDWIRED(0)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .stg_wr_en(stg_wr_en), .stg_dest_addr(stg_dest_addr),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_lat(iss_lat),
    .iss_ready(iss_ready), .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
    .busy_vec(busy_vec)
  );

  distribution_hazard_unit #(
    .NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .NUM_STAGES(NUM_STAGES),
    .MAX_LAT(MAX_LAT), .ZERO_HARDWIRED(1)
  ) dut_z (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .stg_wr_en(stg_wr_en), .stg_dest_addr(stg_dest_addr),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .iss_lat(iss_lat),
    .iss_ready(iss_ready_z), .flush(flush), .fwd_sel(fwd_sel_z), .stall(stall_z),
    .busy_vec(busy_vec_z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && iss_valid) begin
      assert (int'(iss_lat) <= MAX_LAT) else $error("iss_lat %0d above MAX_LAT", iss_lat);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1);
  end

  // comparison and scoreboard
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [3:0] f, input logic s, input logic r);
    exp_q.push_back({f, s, r});
    name_q.push_back(name);
  endtask

  task automatic pop_check();
    logic [OUT_W-1:0] e;
    string            n;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard: got DUT output, expected queue empty");
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      cmp(n, 32'({fwd_sel, stall, iss_ready}), 32'(e));
    end
  endtask

  // drivers
  task automatic drive_id(input logic v, input logic [9:0] src, input logic [1:0] used,
                          input logic [1:0] wr, input logic [9:0] dest);
    id_valid      = v;
    id_src_addr   = src;
    id_src_used   = used;
    stg_wr_en     = wr;
    stg_dest_addr = dest;
  endtask

  task automatic drive_iss(input logic v, input logic [4:0] d, input logic [2:0] l, input logic f);
    iss_valid = v;
    iss_dest  = d;
    iss_lat   = l;
    flush     = f;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_id(1'b0, '0, '0, '0, '0);
    drive_iss(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    next_cycle();
  endtask

  task automatic add_vec(input string n, input logic [9:0] src, input logic [1:0] used,
                         input logic [1:0] wr, input logic [9:0] dest,
                         input logic [3:0] ef, input logic [3:0] efz);
    vec_t v;
    v.name = n; v.src = src; v.used = used; v.wr = wr; v.dest = dest;
    v.exp_fwd = ef; v.exp_fwd_z = efz;
    tbl.push_back(v);
  endtask

  // Reference: walk stages oldest to youngest, letting each later match overwrite.
  function automatic logic [3:0] model_fwd(input logic [9:0] src, input logic [1:0] used,
                                           input logic [1:0] wr, input logic [9:0] dest,
                                           input bit zh);
    logic [3:0] res;
    logic [4:0] s;
    res = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = src[i*ADDR_W +: ADDR_W];
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (used[i] && wr[k] && dest[k*ADDR_W +: ADDR_W] == s && !(zh && s == 5'd0)) begin
          res[i*2 +: 2] = 2'b00;
          res[i*2 + k]  = 1'b1;
        end
      end
    end
    return res;
  endfunction

  initial begin
    logic [9:0] r_src, r_dest;
    logic [1:0] r_used, r_wr;
    logic [5:0] st_b, rd_b;

    rst = 1'b1;
    drive_id(1'b0, '0, '0, '0, '0);
    drive_iss(1'b0, '0, '0, 1'b0);

    // table: {src1,src0}, used, wr, {mem,ex}, expected fwd, expected fwd (zero hardwired)
    add_vec("ex_wins",        {5'd0, 5'd5}, 2'b01, 2'b11, {5'd5, 5'd5}, 4'b0001, 4'b0001);
    add_vec("mem_after_ex",   {5'd0, 5'd5}, 2'b01, 2'b11, {5'd5, 5'd6}, 4'b0010, 4'b0010);
    add_vec("ex_no_write",    {5'd7, 5'd3}, 2'b10, 2'b10, {5'd7, 5'd7}, 4'b1000, 4'b1000);
    add_vec("both_src_ex",    {5'd3, 5'd3}, 2'b11, 2'b01, {5'd9, 5'd3}, 4'b0101, 4'b0101);
    add_vec("unused",         {5'd3, 5'd3}, 2'b00, 2'b11, {5'd3, 5'd3}, 4'b0000, 4'b0000);
    add_vec("no_write",       {5'd3, 5'd3}, 2'b11, 2'b00, {5'd3, 5'd3}, 4'b0000, 4'b0000);
    add_vec("addr0",          {5'd0, 5'd0}, 2'b11, 2'b11, {5'd0, 5'd0}, 4'b0101, 4'b0000);
    add_vec("split",          {5'd9, 5'd2}, 2'b11, 2'b11, {5'd2, 5'd9}, 4'b0110, 4'b0110);
    add_vec("src1_mem_addr0", {5'd0, 5'd4}, 2'b11, 2'b10, {5'd0, 5'd4}, 4'b1000, 4'b0000);

    do_reset();

    // reset state
    drive_id(1'b1, {5'd0, 5'd9}, 2'b01, 2'b00, '0);
    drive_iss(1'b0, 5'd9, 3'd0, 1'b0);
    push_exp("reset_state", 4'b0000, 1'b0, 1'b1);
    sample();
    pop_check();
    cmp("reset_busy", busy_vec, 32'h0);
    next_cycle();

    foreach (tbl[t]) begin
      drive_id(1'b1, tbl[t].src, tbl[t].used, tbl[t].wr, tbl[t].dest);
      drive_iss(1'b0, 5'd0, 3'd0, 1'b0);
      push_exp(tbl[t].name, tbl[t].exp_fwd, 1'b0, 1'b1);
      sample();
      pop_check();
      cmp({tbl[t].name, "_z"}, 32'(fwd_sel_z), 32'(tbl[t].exp_fwd_z));
      next_cycle();
    end

    for (int n = 0; n < 24; n++) begin
      r_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      r_dest = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      r_used = 2'($urandom_range(0, 3));
      r_wr   = 2'($urandom_range(0, 3));
      drive_id(1'b1, r_src, r_used, r_wr, r_dest);
      push_exp($sformatf("rand%0d", n), model_fwd(r_src, r_used, r_wr, r_dest, 1'b0), 1'b0, 1'b1);
      sample();
      pop_check();
      cmp($sformatf("rand%0d_z", n), 32'(fwd_sel_z), 32'(model_fwd(r_src, r_used, r_wr, r_dest, 1'b1)));
      next_cycle();
    end

    // issue dest 9, latency 3, source 9 held
    drive_id(1'b1, {5'd0, 5'd9}, 2'b01, 2'b00, '0);
    drive_iss(1'b1, 5'd9, 3'd3, 1'b0);
    push_exp("lat3_c0", 4'b0000, 1'b0, 1'b1);
    sample();
    pop_check();
    next_cycle();
    drive_iss(1'b0, 5'd9, 3'd0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      push_exp($sformatf("lat3_c%0d", c), 4'b0000, c <= 3, c >= 3);
      sample();
      pop_check();
      cmp($sformatf("lat3_busy_c%0d", c), 32'(busy_vec[9]), 32'(c <= 3));
      next_cycle();
    end

    // WAW reload on the final cycle, no gap
    do_reset();
    drive_id(1'b1, {5'd0, 5'd10}, 2'b01, 2'b00, '0);
    st_b = 6'b011110;
    rd_b = 6'b110101;
    for (int c = 0; c <= 5; c++) begin
      drive_iss(c == 0 || c == 2, 5'd10, (c == 0 || c == 2) ? 3'd2 : 3'd0, 1'b0);
      push_exp($sformatf("waw_c%0d", c), 4'b0000, st_b[c], rd_b[c]);
      sample();
      pop_check();
      next_cycle();
    end

    // flush mid-countdown, then issue with same-cycle flush
    do_reset();
    drive_id(1'b1, {5'd0, 5'd4}, 2'b01, 2'b00, '0);
    drive_iss(1'b1, 5'd4, 3'd5, 1'b0);
    next_cycle();
    drive_iss(1'b0, 5'd4, 3'd0, 1'b0);
    push_exp("flush_c1", 4'b0000, 1'b1, 1'b0);
    sample();
    pop_check();
    cmp("flush_busy_c1", busy_vec, 32'h10);
    next_cycle();
    drive_iss(1'b0, 5'd4, 3'd0, 1'b1);
    push_exp("flush_c2", 4'b0000, 1'b1, 1'b0);
    sample();
    pop_check();
    next_cycle();
    drive_iss(1'b0, 5'd4, 3'd0, 1'b0);
    push_exp("flush_c3", 4'b0000, 1'b0, 1'b1);
    sample();
    pop_check();
    cmp("flush_busy_c3", busy_vec, 32'h0);
    next_cycle();
    drive_iss(1'b1, 5'd4, 3'd5, 1'b1);
    next_cycle();
    drive_iss(1'b0, 5'd4, 3'd0, 1'b0);
    push_exp("iss_flush_same", 4'b0000, 1'b0, 1'b1);
    sample();
    pop_check();
    cmp("iss_flush_busy", busy_vec, 32'h0);
    next_cycle();

    // independent registers, id_valid low gates the stall
    do_reset();
    drive_id(1'b0, {5'd0, 5'd1}, 2'b01, 2'b00, '0);
    drive_iss(1'b1, 5'd1, 3'd2, 1'b0);
    next_cycle();
    drive_iss(1'b1, 5'd2, 3'd1, 1'b0);
    push_exp("novalid_nostall", 4'b0000, 1'b0, 1'b1);
    sample();
    pop_check();
    cmp("indep_busy_c1", busy_vec, 32'h2);
    next_cycle();
    drive_iss(1'b0, 5'd2, 3'd0, 1'b0);
    sample();
    cmp("indep_busy_c2", busy_vec, 32'h6);
    next_cycle();
    sample();
    cmp("indep_busy_c3", busy_vec, 32'h0);
    next_cycle();

    // zero latency is a no-op
    drive_iss(1'b1, 5'd3, 3'd0, 1'b0);
    next_cycle();
    drive_iss(1'b0, 5'd3, 3'd0, 1'b0);
    sample();
    cmp("lat0_busy", busy_vec, 32'h0);
    next_cycle();

    // address 0: normal instance versus hardwired-zero instance
    do_reset();
    drive_id(1'b1, {5'd0, 5'd0}, 2'b01, 2'b11, {5'd0, 5'd0});
    drive_iss(1'b1, 5'd0, 3'd3, 1'b0);
    push_exp("zero_norm_c0", 4'b0001, 1'b0, 1'b1);
    sample();
    pop_check();
    cmp("zero_fwd_z", 32'(fwd_sel_z), 32'h0);
    cmp("zero_ready_z", 32'(iss_ready_z), 32'h1);
    next_cycle();
    drive_iss(1'b0, 5'd0, 3'd0, 1'b0);
    push_exp("zero_norm_c1", 4'b0001, 1'b1, 1'b0);
    sample();
    pop_check();
    cmp("zero_busy_z", busy_vec_z, 32'h0);
    cmp("zero_stall_z", 32'(stall_z), 32'h0);
    cmp("zero_busy_norm", busy_vec, 32'h1);
    next_cycle();

    // asynchronous reset mid-countdown
    do_reset();
    drive_id(1'b1, {5'd0, 5'd12}, 2'b01, 2'b00, '0);
    drive_iss(1'b1, 5'd12, 3'd7, 1'b0);
    next_cycle();
    drive_iss(1'b0, 5'd12, 3'd0, 1'b0);
    repeat (3) next_cycle();
    sample();
    cmp("arst_pre_busy", busy_vec, 32'h1000);
    cmp("arst_pre_stall", 32'(stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    cmp("arst_busy", busy_vec, 32'h0);
    cmp("arst_stall", 32'(stall), 32'h0);
    cmp("arst_ready", 32'(iss_ready), 32'h1);
    #1 rst = 1'b0;
    next_cycle();

    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
